axi_lite_memory_mock: RTL and testbench

//  Simulation-only AXI4-Lite slave memory serving a single RV32I core master over one bus.
//  It holds two word arrays: i_data for instructions (read-only over AXI) and d_data for data (read/write).

---
 rtl/axi_lite_memory_mock_pkg.sv | 33 +++
 rtl/axi_lite_memory_mock.sv | 257 +++++++++++++++++++++++++
 tb/tb_axi_lite_memory_mock.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_memory_mock_pkg.sv
// Shared constants and enumerations for the AXI4-Lite memory mock.
// Holds the bus widths, the memory depth, the AXI response codes, the
// address-decode region tags and the read/write channel state encodings.
package axi_lite_memory_mock_pkg;

  localparam int unsigned AXI_ADDR_WIDTH   = 32;
  localparam int unsigned AXI_DATA_WIDTH   = 32;
  localparam int unsigned MEMORY_NUM_WORDS = 1024;
  localparam int unsigned BYTES_PER_WORD   = AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    REGION_IMEM = 2'd0,
    REGION_DMEM = 2'd1,
    REGION_NONE = 2'd2
  } region_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

  typedef enum logic {
    WR_COLLECT = 1'b0,
    WR_RESP    = 1'b1
  } wr_state_e;

endpackage

// File: rtl/axi_lite_memory_mock.sv
// Simulation AXI4-Lite slave memory for a single RV32I master.
// Two word arrays: i_data (instructions, read-only over the bus) and d_data
// (data, byte-lane writable). Arrays are not reset so benches can preload
// and inspect them hierarchically. One-cycle latency on both channels, which
// run independently.
// Ports:
//   CLK, RSTn            clock; asynchronous active-high reset (despite the name)
//   S_AXI_AW*/W*/B*      write address / data / response channels
//   S_AXI_AR*/R*         read address / data channels
//   S_AXI_*PROT          accepted but ignored
module axi_lite_memory_mock
  import axi_lite_memory_mock_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int unsigned           NUM_WORDS  = MEMORY_NUM_WORDS,
  parameter logic [ADDR_WIDTH-1:0] IMEM_BASE  = ADDR_WIDTH'(32'h0000_0000),
  parameter logic [ADDR_WIDTH-1:0] DMEM_BASE  = ADDR_WIDTH'(32'h0001_0000)
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]              S_AXI_AWPROT,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  output logic [1:0]              S_AXI_BRESP,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]              S_AXI_ARPROT,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP
);

  localparam int unsigned           STRB_W       = DATA_WIDTH / 8;
  localparam int unsigned           IDX_W        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned           LANE_SHIFT   = $clog2(STRB_W);
  localparam logic [ADDR_WIDTH-1:0] REGION_BYTES = ADDR_WIDTH'(NUM_WORDS * STRB_W);

  logic [DATA_WIDTH-1:0] i_data [0:NUM_WORDS-1];
  logic [DATA_WIDTH-1:0] d_data [0:NUM_WORDS-1];

  // Offset-from-base compare; an address below a base wraps to a huge offset
  // and therefore falls outside that region.
  function automatic region_e decode(input logic [ADDR_WIDTH-1:0] imem_off,
                                     input logic [ADDR_WIDTH-1:0] dmem_off);
    if (imem_off < REGION_BYTES)      return REGION_IMEM;
    else if (dmem_off < REGION_BYTES) return REGION_DMEM;
    else                              return REGION_NONE;
  endfunction

  // ---------------- read channel ----------------
  rd_state_e             rd_state_q, rd_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  resp_e                 rresp_q, rresp_d;

  logic [ADDR_WIDTH-1:0] rd_imem_off_c, rd_dmem_off_c;
  region_e               rd_region_c;
  logic [IDX_W-1:0]      rd_imem_idx_c, rd_dmem_idx_c;

  always_comb begin
    rd_imem_off_c = S_AXI_ARADDR - IMEM_BASE;
    rd_dmem_off_c = S_AXI_ARADDR - DMEM_BASE;
    rd_region_c   = decode(rd_imem_off_c, rd_dmem_off_c);
    rd_imem_idx_c = rd_imem_off_c[IDX_W+LANE_SHIFT-1:LANE_SHIFT];
    rd_dmem_idx_c = rd_dmem_off_c[IDX_W+LANE_SHIFT-1:LANE_SHIFT];
  end

  // Read FSM: accept in IDLE, hold the response stable in RESP until RREADY.
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RD_IDLE: begin
        arready_d = 1'b1;
        if (S_AXI_ARVALID && arready_q) begin
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rd_state_d = RD_RESP;
          case (rd_region_c)
            REGION_IMEM: begin rdata_d = i_data[rd_imem_idx_c]; rresp_d = RESP_OKAY; end
            REGION_DMEM: begin rdata_d = d_data[rd_dmem_idx_c]; rresp_d = RESP_OKAY; end
            default:     begin rdata_d = '0;                    rresp_d = RESP_DECERR; end
          endcase
        end
      end
      RD_RESP: begin
        if (S_AXI_RREADY) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RSTn) begin
    if (RSTn) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // ---------------- write channel ----------------
  wr_state_e             wr_state_q, wr_state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  resp_e                 bresp_q, bresp_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;

  logic                  aw_take_c, w_take_c, d_write_c;
  logic [ADDR_WIDTH-1:0] wr_addr_c, wr_imem_off_c, wr_dmem_off_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic [STRB_W-1:0]     wr_strb_c;
  region_e               wr_region_c;
  logic [IDX_W-1:0]      wr_idx_c;

  // Merge a same-cycle handshake with anything already held so the commit
  // can happen on the edge that completes the pair.
  always_comb begin
    aw_take_c     = S_AXI_AWVALID && awready_q;
    w_take_c      = S_AXI_WVALID && wready_q;
    wr_addr_c     = aw_take_c ? S_AXI_AWADDR : awaddr_q;
    wr_data_c     = w_take_c ? S_AXI_WDATA : wdata_q;
    wr_strb_c     = w_take_c ? S_AXI_WSTRB : wstrb_q;
    wr_imem_off_c = wr_addr_c - IMEM_BASE;
    wr_dmem_off_c = wr_addr_c - DMEM_BASE;
    wr_region_c   = decode(wr_imem_off_c, wr_dmem_off_c);
    wr_idx_c      = wr_dmem_off_c[IDX_W+LANE_SHIFT-1:LANE_SHIFT];
  end

  // Write FSM: collect AW and W in any order, commit, then hold B until BREADY.
  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    d_write_c  = 1'b0;
    case (wr_state_q)
      WR_COLLECT: begin
        aw_held_d = aw_held_q || aw_take_c;
        w_held_d  = w_held_q || w_take_c;
        awaddr_d  = wr_addr_c;
        wdata_d   = wr_data_c;
        wstrb_d   = wr_strb_c;
        awready_d = !aw_held_d;
        wready_d  = !w_held_d;
        if (aw_held_d && w_held_d) begin
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
          bvalid_d   = 1'b1;
          wr_state_d = WR_RESP;
          case (wr_region_c)
            REGION_DMEM: begin bresp_d = RESP_OKAY; d_write_c = 1'b1; end
            REGION_IMEM: bresp_d = RESP_SLVERR;
            default:     bresp_d = RESP_DECERR;
          endcase
        end
      end
      WR_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = WR_COLLECT;
        end
      end
      default: wr_state_d = WR_COLLECT;
    endcase
  end

  always_ff @(posedge CLK or posedge RSTn) begin
    if (RSTn) begin
      wr_state_q <= WR_COLLECT;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
    end
  end

  // Data memory byte-lane update; not reset so contents survive reset.
  always_ff @(posedge CLK) begin
    if (d_write_c) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb_c[b]) d_data[wr_idx_c][8*b +: 8] <= wr_data_c[8*b +: 8];
      end
    end
  end

  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;

  // Protection bits and the address bits outside the word index are don't-care.
  logic unused_c;
  assign unused_c = ^{S_AXI_AWPROT, S_AXI_ARPROT, rd_imem_off_c, rd_dmem_off_c,
                      wr_imem_off_c, wr_dmem_off_c};

endmodule

// File: tb/tb_axi_lite_memory_mock.sv
// Scoreboard bench for axi_lite_memory_mock: stimulus pushes expected R/B
// responses into queues, a negedge monitor pops and compares on each handshake.
module tb_axi_lite_memory_mock;

  logic        clk;
  logic        rst;
  logic        aw_valid, aw_ready;
  logic [31:0] aw_addr;
  logic        w_valid, w_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        b_valid, b_ready;
  logic [1:0]  b_resp;
  logic        ar_valid, ar_ready;
  logic [31:0] ar_addr;
  logic        r_valid, r_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;

  axi_lite_memory_mock dut (
    .CLK(clk), .RSTn(rst),
    .S_AXI_AWVALID(aw_valid), .S_AXI_AWREADY(aw_ready), .S_AXI_AWADDR(aw_addr),
    .S_AXI_AWPROT(3'b000),
    .S_AXI_WVALID(w_valid), .S_AXI_WREADY(w_ready), .S_AXI_WDATA(w_data),
    .S_AXI_WSTRB(w_strb),
    .S_AXI_BVALID(b_valid), .S_AXI_BREADY(b_ready), .S_AXI_BRESP(b_resp),
    .S_AXI_ARVALID(ar_valid), .S_AXI_ARREADY(ar_ready), .S_AXI_ARADDR(ar_addr),
    .S_AXI_ARPROT(3'b000),
    .S_AXI_RVALID(r_valid), .S_AXI_RREADY(r_ready), .S_AXI_RDATA(r_data),
    .S_AXI_RRESP(r_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [1:0] wr_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: one compare per accepted R or B beat.
  always @(negedge clk) begin
    if (r_valid && r_ready) begin
      if (rd_q.size() == 0) chk("r_unexpected", 32'(r_valid), 32'd0);
      else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        chk("rdata", r_data, e.data);
        chk("rresp", 32'(r_resp), 32'(e.resp));
      end
    end
    if (b_valid && b_ready) begin
      if (wr_q.size() == 0) chk("b_unexpected", 32'(b_valid), 32'd0);
      else begin
        logic [1:0] e;
        e = wr_q.pop_front();
        chk("bresp", 32'(b_resp), 32'(e));
      end
    end
  end

  // All send tasks are entered just after a rising edge.
  task automatic send_ar(input logic [31:0] a);
    logic ok;
    ok = 1'b0;
    ar_valid = 1'b1; ar_addr = a;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ar_ready) begin ok = 1'b1; break; end
    end
    chk("ar_handshake", 32'(ok), 32'd1);
    @(posedge clk); #1;
    ar_valid = 1'b0;
  endtask

  task automatic send_aw(input logic [31:0] a, input int dly);
    logic ok;
    ok = 1'b0;
    repeat (dly) begin @(posedge clk); #1; end
    aw_valid = 1'b1; aw_addr = a;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (aw_ready) begin ok = 1'b1; break; end
    end
    chk("aw_handshake", 32'(ok), 32'd1);
    @(posedge clk); #1;
    aw_valid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    logic ok;
    ok = 1'b0;
    repeat (dly) begin @(posedge clk); #1; end
    w_valid = 1'b1; w_data = d; w_strb = s;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (w_ready) begin ok = 1'b1; break; end
    end
    chk("w_handshake", 32'(ok), 32'd1);
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (rd_q.size() != 0 || wr_q.size() != 0); i++) @(posedge clk);
    chk("drain_pending", 32'(rd_q.size() + wr_q.size()), 32'd0);
    #1;
  endtask

  task automatic read_exp(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    rd_q.push_back('{data: d, resp: r});
    send_ar(a);
    @(negedge clk);
    chk("rvalid_next_cycle", 32'(r_valid), 32'd1);
    drain();
  endtask

  task automatic write_exp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] r);
    wr_q.push_back(r);
    fork
      send_aw(a, 0);
      send_w(d, s, 0);
    join
    @(negedge clk);
    chk("bvalid_next_cycle", 32'(b_valid), 32'd1);
    drain();
  endtask

  initial begin
    rst = 1'b1;
    aw_valid = 1'b0; aw_addr = '0; w_valid = 1'b0; w_data = '0; w_strb = '0;
    ar_valid = 1'b0; ar_addr = '0; r_ready = 1'b1; b_ready = 1'b1;
    dut.i_data[0]    = 32'h0000_0013;
    dut.i_data[1]    = 32'h0050_0293;
    dut.i_data[1023] = 32'hDEAD_BEEF;
    dut.d_data[0]    = 32'h0000_0000;
    dut.d_data[1]    = 32'h1122_3344;
    dut.d_data[2]    = 32'h7777_7777;
    dut.d_data[3]    = 32'h3333_3333;

    // Reset: every output low while asserted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid", 32'(r_valid), 32'd0);
    chk("rst_bvalid", 32'(b_valid), 32'd0);
    chk("rst_arready", 32'(ar_ready), 32'd0);
    chk("rst_awready", 32'(aw_ready), 32'd0);
    chk("rst_wready", 32'(w_ready), 32'd0);
    chk("rst_rdata", r_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_readies", {29'd0, ar_ready, aw_ready, w_ready}, 32'd7);
    chk("imem0_intact", dut.i_data[0], 32'h0000_0013);
    @(posedge clk); #1;

    // Instruction fetch and decode boundaries.
    read_exp(32'h0000_0004, 32'h0050_0293, OKAY);
    read_exp(32'h0000_0FFC, 32'hDEAD_BEEF, OKAY);
    read_exp(32'h0000_1000, 32'h0000_0000, DECERR);
    read_exp(32'h8000_0000, 32'h0000_0000, DECERR);
    read_exp(32'h0001_0006, 32'h1122_3344, OKAY);

    // Byte-lane write with AW and W together.
    write_exp(32'h0001_0000, 32'hAABB_CCDD, 4'b0011, OKAY);
    chk("dmem0_bytelane", dut.d_data[0], 32'h0000_CCDD);
    read_exp(32'h0001_0000, 32'h0000_CCDD, OKAY);

    // W two cycles ahead of AW, then B backpressure for three cycles.
    b_ready = 1'b0;
    wr_q.push_back(OKAY);
    fork
      send_aw(32'h0001_0004, 2);
      send_w(32'hCAFE_F00D, 4'b1111, 0);
    join
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_bvalid", 32'(b_valid), 32'd1);
      chk("bp_readies", {30'd0, aw_ready, w_ready}, 32'd0);
    end
    b_ready = 1'b1;
    @(posedge clk); #1;
    drain();
    @(negedge clk);
    chk("bp_readies_back", {30'd0, aw_ready, w_ready}, 32'd3);
    chk("dmem1_split", dut.d_data[1], 32'hCAFE_F00D);
    @(posedge clk); #1;

    // Zero strobe: OKAY, no change. Error responses leave memory alone.
    write_exp(32'h0001_0004, 32'h0BAD_0BAD, 4'b0000, OKAY);
    chk("dmem1_strb0", dut.d_data[1], 32'hCAFE_F00D);
    write_exp(32'h0000_0000, 32'hFFFF_FFFF, 4'b1111, SLVERR);
    chk("imem0_slverr", dut.i_data[0], 32'h0000_0013);
    write_exp(32'h8000_0000, 32'hFFFF_FFFF, 4'b1111, DECERR);

    // Same-edge read of the word being committed sees the old value.
    rd_q.push_back('{data: 32'h7777_7777, resp: OKAY});
    wr_q.push_back(OKAY);
    fork
      send_ar(32'h0001_0008);
      send_aw(32'h0001_0008, 0);
      send_w(32'h0000_0055, 4'b1111, 0);
    join
    drain();
    read_exp(32'h0001_0008, 32'h0000_0055, OKAY);

    // Reset with only W captured: the W must be discarded.
    send_w(32'h0000_0BAD, 4'b1111, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_bvalid", 32'(b_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_readies", {29'd0, ar_ready, aw_ready, w_ready}, 32'd7);
    chk("midrst_dmem3", dut.d_data[3], 32'h3333_3333);
    @(posedge clk); #1;
    write_exp(32'h0001_000C, 32'h0000_600D, 4'b1111, OKAY);
    chk("post_midrst_dmem3", dut.d_data[3], 32'h0000_600D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1);
  end

endmodule
